mem_router: RTL and testbench
=============================

# mem_router

Parametrised memory-mapped bus router between the core's load/store port and N target peripherals (SRAM, UART, timers, …). It decodes each request against a table of base/mask regions and forwards it to exactly one target with a valid/ready handshake. It returns read data or an error response, and flags unmapped addresses, writes to read-only regions and unresponsive targets through a per-access timeout.

## Interface
- NUM_REGIONS, 4, number of target regions/channels (1–8)
- ADDR_W, 32, address width
- DATA_W, 32, data width (multiple of 8)
- REGION_BASE, mem_map_pkg::DEFAULT_BASE, packed NUM_REGIONS×ADDR_W base addresses; region i at slice i
- REGION_MASK, mem_map_pkg::DEFAULT_MASK, packed NUM_REGIONS×ADDR_W masks; hit when (addr & mask) == base
- REGION_RO, '0, NUM_REGIONS bits; bit i set = region i read-only
- TIMEOUT, 15, max cycles waiting for tgt_ready before error (≥1)
- clk  in  1  clock
- rst_n  in  1  reset: one clock; reset is synchronous and active-low
- req_valid  in  1  core request valid
- req_ready  out  1  router accepts request (IDLE only)
- req_we  in  1  1 = write
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  write data
- req_be  in  DATA_W/8  byte enables
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  DATA_W  read data (0 on writes/errors)
- rsp_err  out  1  access error, valid with rsp_valid
- tgt_valid  out  NUM_REGIONS  one-hot target strobe
- tgt_we  out  1  forwarded write enable
- tgt_addr  out  ADDR_W  offset = req_addr & ~mask
- tgt_wdata  out  DATA_W  forwarded write data
- tgt_be  out  DATA_W/8  forwarded byte enables
- tgt_ready  in  NUM_REGIONS  target completion, per channel
- tgt_rdata  in  NUM_REGIONS×DATA_W  per-target read data, sampled with tgt_ready
- fault_clr  in  1  clears fault log
- fault_valid  out  1  sticky fault flag
- fault_addr  out  ADDR_W  address of first fault
- fault_cause  out  2  00 none, 01 unmapped, 10 RO write, 11 timeout

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid, latch we/addr/wdata/be and decode; the lowest-index hit wins on overlap.
  - Hit on a writable region, or a read: go to ACCESS with sel = hit index.
  - Miss, or write to a REGION_RO region: go to RESP with err=1; no target strobe.
- ACCESS: tgt_valid[sel]=1 and all tgt_* held stable.
  - On tgt_ready[sel]: capture tgt_rdata slice sel (reads only) and go to RESP, err=0.
  - Timeout counter is cleared on entry and increments each cycle. When count==TIMEOUT without ready, go to RESP with err=1 and cause timeout.
  - tgt_ready of non-selected channels is ignored.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. The core must accept it; there is no rsp backpressure.
- Errors update the fault log only when fault_valid==0 (first fault held). fault_clr has priority over a simultaneous new fault.
- Reset mid-ACCESS: tgt_valid drops the next cycle and the transaction is abandoned; no response is issued.

## Timing
- Reset values: req_ready=0 during reset, 1 from the first cycle after release. rsp_valid=0, rsp_rdata=0, rsp_err=0, tgt_valid=0, tgt_* =0, fault_*=0, FSM=IDLE.
- Decode is combinational on req_addr in IDLE; all outputs are registered.
- Accept at cycle 0 → tgt_valid at 1 → tgt_ready at 1 → rsp_valid at 2. Best-case latency is 2 cycles; throughput is 1 access per 3 cycles.
- Decode error: accept at 0 → rsp_valid/rsp_err at 1.
- Timeout: tgt_valid at cycles 1..TIMEOUT+1 → rsp_err at TIMEOUT+2.
- tgt_ready on the same cycle the counter hits TIMEOUT counts as success.
- The timeout counter is $clog2(TIMEOUT+1) bits and saturates; it never wraps.

## Configuration
- MEM_ROUTER_FAULT_LOG_EN defined: the sticky fault_valid/fault_addr/fault_cause registers and fault_clr are implemented.
- Undefined: the fault ports remain and are tied to 0, fault_clr is ignored, and rsp_err behaviour is unchanged.

## Structure
- mem_map_pkg holds:
  - state enum (IDLE/ACCESS/RESP)
  - fault_cause enum
  - DEFAULT_BASE/DEFAULT_MASK for the SoC map: SRAM 0x8000_2000/0xFFFF_E000, UART 0x1000_0000/0xFFFF_FFE0, others unmapped
  - MEM_SEL constants
- Sub-module mem_router_decode: combinational priority region matcher. It outputs hit, sel index and RO flag.

## Test plan
- Read 0x8000_2010, SRAM returns ready in the same cycle with 0xDEAD_BEEF → tgt_addr=0x10, rsp_valid at cycle 2, rdata=0xDEAD_BEEF, err=0.
- Write 0x1000_0004 with be=0001, UART ready after 3 cycles → only tgt_valid[1] set for 3 cycles, then rsp_valid with err=0.
- Read 0x0000_0000 (unmapped) → no tgt_valid, rsp_err at cycle 1, fault_cause=01, fault_addr=0x0.
- Region 2 never asserts ready, TIMEOUT=15 → rsp_err at cycle 17, fault_cause=11. A second fault leaves fault_addr unchanged until fault_clr is pulsed.
- Write to a REGION_RO region → err with cause 10 and no strobe. An overlapping-region address routes to the lower index.
- rst_n asserted during ACCESS → tgt_valid=0 next cycle, no rsp_valid; a fresh read after reset completes normally.

Source files
------------

// File: rtl/mem_map_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_map_pkg                                                                |
// | Shared types and the default SoC address map for mem_router.               |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package mem_map_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_UNMAPPED = 2'd1,
        CAUSE_RO_WRITE = 2'd2,
        CAUSE_TIMEOUT  = 2'd3
    } fault_cause_t;

    localparam int MEM_SEL_SRAM   = 0;
    localparam int MEM_SEL_UART   = 1;
    localparam int MEM_SEL_TIMER0 = 2;
    localparam int MEM_SEL_TIMER1 = 3;

    // Unused slots get mask 0 with a non-zero base so they can never match.
    localparam logic [4*32-1:0] DEFAULT_BASE = {
        32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1000_0000, 32'h8000_2000
    };
    localparam logic [4*32-1:0] DEFAULT_MASK = {
        32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFE0, 32'hFFFF_E000
    };

endpackage
`default_nettype wire

// File: rtl/mem_router_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_router_decode                                                          |
// | Combinational base/mask region matcher; lowest matching index wins.        |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module mem_router_decode #(
    parameter int                             NUM_REGIONS = 4,
    parameter int                             ADDR_W      = 32,
    parameter int                             SEL_W       = 2,
    parameter logic [NUM_REGIONS*ADDR_W-1:0]  REGION_BASE = '0,
    parameter logic [NUM_REGIONS*ADDR_W-1:0]  REGION_MASK = '0,
    parameter logic [NUM_REGIONS-1:0]         REGION_RO   = '0
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_hit,
    output logic [SEL_W-1:0]  o_sel,
    output logic              o_ro
);

    logic [NUM_REGIONS-1:0] w_match;

    for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
        assign w_match[gi] = (i_addr & REGION_MASK[gi*ADDR_W +: ADDR_W])
                             == REGION_BASE[gi*ADDR_W +: ADDR_W];
    end

    // Scan downwards so the last assignment is the lowest matching index.
    always_comb begin
        o_hit = 1'b0;
        o_sel = '0;
        o_ro  = 1'b0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                o_hit = 1'b1;
                o_sel = SEL_W'(i);
                o_ro  = REGION_RO[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_router.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_router                                                                 |
// | Load/store bus router: region decode, target handshake, timeout, fault log.|
// | Optional: MEM_ROUTER_FAULT_LOG_EN enables the sticky fault log.            |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module mem_router
    import mem_map_pkg::*;
#(
    parameter int                             NUM_REGIONS = 4,
    parameter int                             ADDR_W      = 32,
    parameter int                             DATA_W      = 32,
    parameter logic [NUM_REGIONS*ADDR_W-1:0]  REGION_BASE = DEFAULT_BASE,
    parameter logic [NUM_REGIONS*ADDR_W-1:0]  REGION_MASK = DEFAULT_MASK,
    parameter logic [NUM_REGIONS-1:0]         REGION_RO   = '0,
    parameter int                             TIMEOUT     = 15
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_we,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic [DATA_W-1:0]             req_wdata,
    input  logic [DATA_W/8-1:0]           req_be,
    output logic                          rsp_valid,
    output logic [DATA_W-1:0]             rsp_rdata,
    output logic                          rsp_err,
    output logic [NUM_REGIONS-1:0]        tgt_valid,
    output logic                          tgt_we,
    output logic [ADDR_W-1:0]             tgt_addr,
    output logic [DATA_W-1:0]             tgt_wdata,
    output logic [DATA_W/8-1:0]           tgt_be,
    input  logic [NUM_REGIONS-1:0]        tgt_ready,
    input  logic [NUM_REGIONS*DATA_W-1:0] tgt_rdata,
    input  logic                          fault_clr,
    output logic                          fault_valid,
    output logic [ADDR_W-1:0]             fault_addr,
    output logic [1:0]                    fault_cause
);

    localparam int c_sel_w = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam int c_cnt_w = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(TIMEOUT);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_req_ready;
    logic                   r_rsp_valid;
    logic [DATA_W-1:0]      r_rsp_rdata;
    logic                   r_rsp_err;
    logic [NUM_REGIONS-1:0] r_tgt_valid;
    logic                   r_tgt_we;
    logic [ADDR_W-1:0]      r_tgt_addr;
    logic [DATA_W-1:0]      r_tgt_wdata;
    logic [DATA_W/8-1:0]    r_tgt_be;
    logic [ADDR_W-1:0]      r_addr;
    logic [c_sel_w-1:0]     r_sel;
    logic [c_cnt_w-1:0]     r_cnt;

    logic                   w_hit;
    logic                   w_ro;
    logic [c_sel_w-1:0]     w_sel;
    logic [c_sel_w-1:0]     w_sel_nxt;
    logic [ADDR_W-1:0]      w_mask;
    logic                   w_accept;
    logic                   w_done_ok;
    logic                   w_err_nxt;
    fault_cause_t           w_cause_nxt;
    logic [ADDR_W-1:0]      w_fault_addr;

    mem_router_decode #(
        .NUM_REGIONS (NUM_REGIONS),
        .ADDR_W      (ADDR_W),
        .SEL_W       (c_sel_w),
        .REGION_BASE (REGION_BASE),
        .REGION_MASK (REGION_MASK),
        .REGION_RO   (REGION_RO)
    ) u_decode (
        .i_addr (req_addr),
        .o_hit  (w_hit),
        .o_sel  (w_sel),
        .o_ro   (w_ro)
    );

    assign w_mask       = REGION_MASK[w_sel*ADDR_W +: ADDR_W];
    assign w_sel_nxt    = (r_state == IDLE) ? w_sel : r_sel;
    assign w_fault_addr = (r_state == IDLE) ? req_addr : r_addr;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done_ok   = 1'b0;
        w_err_nxt   = 1'b0;
        w_cause_nxt = CAUSE_NONE;
        case (r_state)
            IDLE: begin
                if (req_valid && r_req_ready) begin
                    w_accept = 1'b1;
                    if (!w_hit) begin
                        w_state_nxt = RESP;
                        w_err_nxt   = 1'b1;
                        w_cause_nxt = CAUSE_UNMAPPED;
                    end else if (req_we && w_ro) begin
                        w_state_nxt = RESP;
                        w_err_nxt   = 1'b1;
                        w_cause_nxt = CAUSE_RO_WRITE;
                    end else begin
                        w_state_nxt = ACCESS;
                    end
                end
            end
            ACCESS: begin
                // Ready in the same cycle the counter reaches the limit still succeeds.
                if (tgt_ready[r_sel]) begin
                    w_state_nxt = RESP;
                    w_done_ok   = 1'b1;
                end else if (r_cnt == c_timeout) begin
                    w_state_nxt = RESP;
                    w_err_nxt   = 1'b1;
                    w_cause_nxt = CAUSE_TIMEOUT;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_tgt_valid <= '0;
            r_tgt_we    <= 1'b0;
            r_tgt_addr  <= '0;
            r_tgt_wdata <= '0;
            r_tgt_be    <= '0;
            r_addr      <= '0;
            r_sel       <= '0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= (w_state_nxt == IDLE);
            r_rsp_valid <= (w_state_nxt == RESP);
            r_rsp_err   <= w_err_nxt;
            r_rsp_rdata <= (w_done_ok && !r_tgt_we) ? tgt_rdata[r_sel*DATA_W +: DATA_W] : '0;
            r_tgt_valid <= (w_state_nxt == ACCESS) ? (NUM_REGIONS'(1) << w_sel_nxt) : '0;
            if (w_accept) begin
                r_tgt_we    <= req_we;
                r_tgt_addr  <= req_addr & ~w_mask;
                r_tgt_wdata <= req_wdata;
                r_tgt_be    <= req_be;
                r_addr      <= req_addr;
                r_sel       <= w_sel;
            end
            if (r_state == ACCESS && w_state_nxt == ACCESS) begin
                r_cnt <= (r_cnt == c_timeout) ? r_cnt : r_cnt + c_cnt_w'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign tgt_valid = r_tgt_valid;
    assign tgt_we    = r_tgt_we;
    assign tgt_addr  = r_tgt_addr;
    assign tgt_wdata = r_tgt_wdata;
    assign tgt_be    = r_tgt_be;

`ifdef MEM_ROUTER_FAULT_LOG_EN
    logic              r_fault_valid;
    logic [ADDR_W-1:0] r_fault_addr;
    logic [1:0]        r_fault_cause;

    // A clear wins over a fault arriving on the same edge; otherwise the first fault sticks.
    always_ff @(posedge clk) begin
        if (!rst_n || fault_clr) begin
            r_fault_valid <= 1'b0;
            r_fault_addr  <= '0;
            r_fault_cause <= 2'b00;
        end else if (w_err_nxt && !r_fault_valid) begin
            r_fault_valid <= 1'b1;
            r_fault_addr  <= w_fault_addr;
            r_fault_cause <= w_cause_nxt;
        end
    end

    assign fault_valid = r_fault_valid;
    assign fault_addr  = r_fault_addr;
    assign fault_cause = r_fault_cause;
`else
    logic w_unused_fault;
    assign w_unused_fault = ^{fault_clr, w_fault_addr, w_cause_nxt};

    assign fault_valid = 1'b0;
    assign fault_addr  = '0;
    assign fault_cause = 2'b00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_router.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_router                                                              |
// | Randomized self-checking bench against a region-table reference model.     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_mem_router;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 15;
    localparam logic [NR*AW-1:0] c_base = {32'h2000_0000, 32'h2000_0000, 32'h1000_0000, 32'h8000_2000};
    localparam logic [NR*AW-1:0] c_mask = {32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_FFE0, 32'hFFFF_E000};
    localparam logic [NR-1:0]    c_ro   = 4'b1000;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic           req_we = 1'b0;
    logic [AW-1:0]  req_addr = '0;
    logic [DW-1:0]  req_wdata = '0;
    logic [3:0]     req_be = '0;
    logic           rsp_valid;
    logic [DW-1:0]  rsp_rdata;
    logic           rsp_err;
    logic [NR-1:0]  tgt_valid;
    logic           tgt_we;
    logic [AW-1:0]  tgt_addr;
    logic [DW-1:0]  tgt_wdata;
    logic [3:0]     tgt_be;
    logic [NR-1:0]  tgt_ready = '0;
    logic [NR*DW-1:0] tgt_rdata = '0;
    logic           fault_clr = 1'b0;
    logic           fault_valid;
    logic [AW-1:0]  fault_addr;
    logic [1:0]     fault_cause;

    always #5 clk = ~clk;

    mem_router #(
        .NUM_REGIONS (NR), .ADDR_W (AW), .DATA_W (DW),
        .REGION_BASE (c_base), .REGION_MASK (c_mask), .REGION_RO (c_ro), .TIMEOUT (TO)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .req_valid (req_valid), .req_ready (req_ready), .req_we (req_we),
        .req_addr (req_addr), .req_wdata (req_wdata), .req_be (req_be),
        .rsp_valid (rsp_valid), .rsp_rdata (rsp_rdata), .rsp_err (rsp_err),
        .tgt_valid (tgt_valid), .tgt_we (tgt_we), .tgt_addr (tgt_addr),
        .tgt_wdata (tgt_wdata), .tgt_be (tgt_be), .tgt_ready (tgt_ready),
        .tgt_rdata (tgt_rdata), .fault_clr (fault_clr), .fault_valid (fault_valid),
        .fault_addr (fault_addr), .fault_cause (fault_cause)
    );

    int n_cmp = 0;
    int n_mis = 0;

    logic [AW-1:0] mbase [NR];
    logic [AW-1:0] mmask [NR];
    logic          mdl_fv = 1'b0;
    logic [AW-1:0] mdl_fa = '0;
    logic [1:0]    mdl_fc = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int mdl_decode(input logic [AW-1:0] a);
        for (int i = 0; i < NR; i++)
            if ((a & mmask[i]) == mbase[i]) return i;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_fault(input string tag);
`ifdef MEM_ROUTER_FAULT_LOG_EN
        check({tag, "_fv"}, fault_valid, mdl_fv);
        check({tag, "_fa"}, fault_addr, mdl_fa);
        check({tag, "_fc"}, fault_cause, mdl_fc);
`else
        check({tag, "_fv"}, fault_valid, 0);
        check({tag, "_fa"}, fault_addr, 0);
        check({tag, "_fc"}, fault_cause, 0);
`endif
    endtask

    // delay: cycles after the strobe rises before the target answers; -1 = never.
    task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           input logic [3:0] be, input int delay, input logic [DW-1:0] rd,
                           input logic clr);
        int idx, strobes, rsp_at, n_wait, seen, bad, got_at;
        logic e_err, dec_err, got_err;
        logic [1:0] e_cause;
        logic [DW-1:0] e_rdata, got_rdata, f_wdata;
        logic [AW-1:0] f_addr;
        logic [3:0] oh, f_be;
        logic f_we;
        idx = mdl_decode(addr);
        e_err = 0; dec_err = 0; e_cause = 0; e_rdata = 0; strobes = 0;
        if (idx < 0) begin
            e_err = 1; dec_err = 1; e_cause = 2'd1;
        end else if (we && c_ro[idx]) begin
            e_err = 1; dec_err = 1; e_cause = 2'd2;
        end else if (delay < 0 || delay > TO) begin
            e_err = 1; e_cause = 2'd3; strobes = TO + 1;
        end else begin
            strobes = delay + 1;
            if (!we) e_rdata = rd;
        end
        rsp_at = dec_err ? 1 : strobes + 1;
        oh = (strobes > 0) ? 4'(1 << idx) : 4'b0;

        n_wait = 0;
        while (!req_ready && n_wait < 20) begin
            tick();
            n_wait++;
        end
        check("req_ready", req_ready, 1);
        req_valid = 1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be; fault_clr = clr;
        tick();
        req_valid = 0; fault_clr = 0;
        req_we = ~we; req_addr = $urandom; req_wdata = $urandom; req_be = ~be;

        if (clr) begin
            mdl_fv = 0; mdl_fa = 0; mdl_fc = 0;
        end
        if (e_err && !(clr && dec_err) && !mdl_fv) begin
            mdl_fv = 1; mdl_fa = addr; mdl_fc = e_cause;
        end

        seen = 0; bad = 0; got_at = 0; got_err = 0; got_rdata = 0;
        f_addr = 0; f_we = 0; f_wdata = 0; f_be = 0;
        for (int c = 1; c <= TO + 4 && got_at == 0; c++) begin
            if (tgt_valid != 0) begin
                seen++;
                if (tgt_valid !== oh) bad++;
                if (seen == 1) begin
                    f_addr = tgt_addr; f_we = tgt_we; f_wdata = tgt_wdata; f_be = tgt_be;
                end
            end
            if (rsp_valid) begin
                got_at = c; got_err = rsp_err; got_rdata = rsp_rdata;
            end else begin
                tgt_ready = 4'($urandom) & ~oh;
                tgt_rdata = {$urandom, $urandom, $urandom, $urandom};
                if (oh != 0 && delay >= 0 && c == 1 + delay) begin
                    tgt_ready = tgt_ready | oh;
                    tgt_rdata[idx*DW +: DW] = rd;
                end
                tick();
            end
        end
        check("strobe_cycles", seen, strobes);
        check("strobe_wrong_chan", bad, 0);
        check("rsp_latency", got_at, rsp_at);
        check("rsp_err", got_err, e_err);
        check("rsp_rdata", got_rdata, e_rdata);
        if (strobes > 0) begin
            check("tgt_addr", f_addr, addr & ~mmask[idx]);
            check("tgt_we", f_we, we);
            if (we) begin
                check("tgt_wdata", f_wdata, wd);
                check("tgt_be", f_be, be);
            end
        end
        check_fault("fault");
        tgt_ready = 0;
        tick();
        check("rsp_one_cycle", rsp_valid, 0);
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            mbase[i] = c_base[i*AW +: AW];
            mmask[i] = c_mask[i*AW +: AW];
        end

        repeat (3) tick();
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_tgt_valid", tgt_valid, 0);
        check("rst_tgt_addr", tgt_addr, 0);
        check_fault("rst");
        rst_n = 1;
        tick();
        check("post_rst_ready", req_ready, 1);

        run_txn(0, 32'h8000_2010, 32'h0, 4'hF, 0, 32'hDEAD_BEEF, 0);
        run_txn(1, 32'h1000_0004, 32'h0000_00A5, 4'b0001, 2, 32'h0, 0);
        run_txn(0, 32'h0000_0000, 32'h0, 4'hF, 0, 32'h0, 0);
        run_txn(0, 32'h2000_0040, 32'h0, 4'hF, -1, 32'h0, 0);
        fault_clr = 1;
        tick();
        fault_clr = 0;
        mdl_fv = 0; mdl_fa = 0; mdl_fc = 0;
        check_fault("clr");
        run_txn(0, 32'h2000_0040, 32'h0, 4'hF, -1, 32'h0, 0);
        run_txn(1, 32'h2000_8000, 32'h1234_5678, 4'hF, 0, 32'h0, 1);
        run_txn(1, 32'h2000_8004, 32'h1234_5678, 4'hF, 0, 32'h0, 0);
        run_txn(0, 32'h2000_0100, 32'h0, 4'hF, 1, 32'hCAFE_F00D, 0);
        run_txn(0, 32'h2000_9000, 32'h0, 4'hF, 0, 32'h0BAD_CAFE, 0);
        run_txn(0, 32'h8000_3FFC, 32'h0, 4'hF, TO, 32'h5555_AAAA, 0);
        run_txn(0, 32'h1000_001C, 32'h0, 4'hF, TO + 1, 32'h5555_AAAA, 1);

        // Reset in the middle of an access abandons it silently.
        begin
            logic any_rsp;
            logic [NR-1:0] any_strobe;
            while (!req_ready) tick();
            req_valid = 1; req_we = 0; req_addr = 32'h2000_0100;
            tick();
            req_valid = 0;
            tick();
            tick();
            check("pre_rst_strobe", tgt_valid, 4'b0100);
            rst_n = 0;
            tick();
            rst_n = 1;
            check("rst_drop_strobe", tgt_valid, 0);
            mdl_fv = 0; mdl_fa = 0; mdl_fc = 0;
            any_rsp = 0; any_strobe = 0;
            for (int c = 0; c < 5; c++) begin
                any_rsp = any_rsp | rsp_valid;
                any_strobe = any_strobe | tgt_valid;
                tick();
            end
            check("rst_no_rsp", any_rsp, 0);
            check("rst_no_strobe", any_strobe, 0);
            check_fault("rst_mid");
        end
        run_txn(0, 32'h8000_2020, 32'h0, 4'hF, 1, 32'h0123_4567, 0);

        for (int k = 0; k < 40; k++) begin
            int cls, dly;
            logic [AW-1:0] a;
            cls = $urandom_range(0, 4);
            case (cls)
                0:       a = 32'h8000_2000 | ($urandom & 32'h1FFC);
                1:       a = 32'h1000_0000 | ($urandom & 32'h1C);
                2:       a = 32'h2000_0000 | ($urandom & 32'hFFC);
                3:       a = 32'h2000_8000 | ($urandom & 32'h7FFC);
                default: a = $urandom;
            endcase
            dly = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5));
            run_txn(1'($urandom), a, $urandom, 4'($urandom), dly, $urandom,
                    1'($urandom_range(0, 9) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
